// File: rtl/booth_ks_alu_seq.sv
// booth_ks_alu_seq
//
// Sequential add / signed-multiply unit behind a start/busy/done handshake.
//   - Add (mode=0): unsigned WIDTH-bit sum with carry-out. It completes on
//     the accepting edge.
//   - Multiply (mode=1): signed WIDTH x WIDTH radix-2 Booth multiply. It
//     runs one Booth step per clock and completes WIDTH cycles after accept.
// Results are registered. They hold until the next operation completes.
// Only the results of the completed mode are non-zero.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   request, accepted in IDLE or DONE
//   mode     in   0 = add, 1 = multiply (captured with start)
//   a, b     in   WIDTH-bit operands
//   busy     out  multiply in progress
//   done     out  one-cycle pulse when a result is written
//   sum      out  registered add result
//   carry    out  registered add carry-out
//   product  out  registered 2*WIDTH-bit signed product

module booth_ks_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     sum,
    output logic                 carry,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state, next_state;

    logic [PW-1:0]    m;       // multiplicand, shifted left one place per step
    logic [PW-1:0]    p;       // partial product accumulator
    logic [WIDTH-1:0] q;       // multiplier, shifted right one place per step
    logic             q_1;     // previous multiplier LSB
    logic [CW-1:0]    count;   // Booth step index

    logic             accept;
    logic [PW-1:0]    p_step;

    // State register
    // NOTE: sequential state is always assigned with non-blocking (<=), so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake outputs
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and a latch is inferred.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                accept = start;
            end
            MUL: begin
                busy = 1'b1;
                if (count == LAST_STEP) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                accept = start;
                if (!start) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (accept) begin
            next_state = mode ? MUL : DONE;
        end
    end

    // One Booth step. The pair {Q[0], q_1} selects add M, subtract M, or hold.
    always_comb begin
        unique case ({q[0], q_1})
            2'b01:   p_step = p + m;
            2'b10:   p_step = p - m;
            default: p_step = p;
        endcase
    end

    // Datapath and result registers
    // NOTE: the datapath registers are reset as well as the state. A reset
    // mid-multiply must leave nothing behind, and the outputs must read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= '0;
            p       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            sum     <= '0;
            carry   <= 1'b0;
            product <= '0;
        end else if (accept) begin
            if (!mode) begin
                {carry, sum} <= {1'b0, a} + {1'b0, b};
                product      <= '0;
            end else begin
                m     <= {{WIDTH{a[WIDTH-1]}}, a};
                p     <= '0;
                q     <= b;
                q_1   <= 1'b0;
                count <= '0;
            end
        end else if (state == MUL) begin
            p     <= p_step;
            m     <= m << 1;
            q_1   <= q[0];
            q     <= q >> 1;
            count <= count + CW'(1);
            if (count == LAST_STEP) begin
                product <= p_step;
                sum     <= '0;
                carry   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_booth_ks_alu_seq.sv
// Testbench for booth_ks_alu_seq.
// Stimulus pushes the expected result into a scoreboard queue. A monitor
// for each instance pops the queue and compares whenever done is high.
// The WIDTH=8 instance takes directed vectors. The WIDTH=3 instance is
// swept exhaustively against a behavioural model.

module tb_booth_ks_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // WIDTH = 8 instance
    logic        rst8, start8, mode8, busy8, done8, carry8;
    logic [7:0]  a8, b8, sum8;
    logic [15:0] product8;

    booth_ks_alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .product(product8)
    );

    // WIDTH = 3 instance
    logic        rst3, start3, mode3, busy3, done3, carry3;
    logic [2:0]  a3, b3, sum3;
    logic [5:0]  product3;

    booth_ks_alu_seq #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .mode(mode3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .sum(sum3), .carry(carry3), .product(product3)
    );

    // Expected {sum, carry, product}
    logic [24:0] sb8[$];
    logic [9:0]  sb3[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors
    initial begin
        logic [24:0] exp8;
        forever begin
            @(negedge clk);
            if (!rst8 && done8) begin
                check("busy_done_excl8", 64'(busy8), 64'(0));
                if (sb8.size() == 0) begin
                    check("spurious_done8", 64'(done8), 64'(0));
                end else begin
                    exp8 = sb8.pop_front();
                    check("result8", 64'({sum8, carry8, product8}), 64'(exp8));
                end
            end
        end
    end

    initial begin
        logic [9:0] exp3;
        forever begin
            @(negedge clk);
            if (!rst3 && done3) begin
                check("busy_done_excl3", 64'(busy3), 64'(0));
                if (sb3.size() == 0) begin
                    check("spurious_done3", 64'(done3), 64'(0));
                end else begin
                    exp3 = sb3.pop_front();
                    check("result3", 64'({sum3, carry3, product3}), 64'(exp3));
                end
            end
        end
    end

    // Called at the negedge just after the accept edge.
    task automatic wait_done8(input int exp_lat);
        int lat = 0;
        check("busy_after_accept8", 64'(busy8), 64'(exp_lat != 0));
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency8", 64'(lat), 64'(exp_lat));
    endtask

    task automatic issue8(input logic m, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] es, input logic ec, input logic [15:0] ep);
        sb8.push_back({es, ec, ep});
        @(negedge clk);
        start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
        @(negedge clk);
        // Scramble the inputs to show that the operands were captured.
        start8 = 1'b0; mode8 = ~m; a8 = ~x; b8 = ~y;
        wait_done8(m ? 8 : 0);
    endtask

    task automatic issue3(input logic m, input logic [2:0] x, input logic [2:0] y,
                          input logic [2:0] es, input logic ec, input logic [5:0] ep);
        int lat = 0;
        sb3.push_back({es, ec, ep});
        @(negedge clk);
        start3 = 1'b1; mode3 = m; a3 = x; b3 = y;
        @(negedge clk);
        start3 = 1'b0; mode3 = ~m; a3 = ~x; b3 = ~y;
        while (!done3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency3", 64'(lat), 64'(m ? 3 : 0));
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst8 = 1'b1; start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
        rst3 = 1'b1; start3 = 1'b0; mode3 = 1'b0; a3 = '0; b3 = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs8", 64'({busy8, done8, sum8, carry8, product8}), 64'(0));
        check("reset_outputs3", 64'({busy3, done3, sum3, carry3, product3}), 64'(0));
        rst8 = 1'b0;
        rst3 = 1'b0;

        // Directed vectors, WIDTH=8
        issue8(1'b0, 8'd200, 8'd100, 8'd44, 1'b1, 16'h0000);  // 300 = 0x12C
        issue8(1'b1, 8'hFD,  8'd5,   8'd0,  1'b0, 16'hFFF1);  // -3 * 5 = -15
        issue8(1'b1, 8'h80,  8'h80,  8'd0,  1'b0, 16'h4000);  // (-128)^2
        issue8(1'b1, 8'h7F,  8'h80,  8'd0,  1'b0, 16'hC080);  // 127 * -128
        issue8(1'b0, 8'hFF,  8'h01,  8'h00, 1'b1, 16'h0000);  // 255 + 1
        // Outputs hold while idle.
        repeat (3) @(negedge clk);
        check("hold_outputs8", 64'({sum8, carry8, product8}), 64'({8'h00, 1'b1, 16'h0000}));

        // Start while busy is ignored: 6 * -7 = -42 = 0xFFD6.
        sb8.push_back({8'd0, 1'b0, 16'hFFD6});
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b1; a8 = 8'd6; b8 = 8'hF9;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(5);
        repeat (4) @(negedge clk);

        // Reset mid-multiply: the operation is aborted with no done pulse.
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b1; a8 = 8'd10; b8 = 8'd10;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        #1;
        check("reset_mid_mul8", 64'({busy8, done8, sum8, carry8, product8}), 64'(0));
        @(negedge clk);
        rst8 = 1'b0;
        repeat (12) @(negedge clk);
        issue8(1'b1, 8'd7, 8'd7, 8'd0, 1'b0, 16'd49);

        // Back-to-back: each new start is issued in the previous DONE cycle.
        sb8.push_back({8'd0, 1'b0, 16'hFFE8});  // 12 * -2 = -24
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b1; a8 = 8'd12; b8 = 8'hFE;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(8);
        sb8.push_back({8'd30, 1'b0, 16'h0000});
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'd10; b8 = 8'd20;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(0);
        sb8.push_back({8'd0, 1'b0, 16'h3F01});  // 127 * 127 = 16129
        start8 = 1'b1; mode8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(8);

        // Exhaustive sweep, WIDTH=3, against a behavioural model.
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                int sx, sy, s;
                sx = (x >= 4) ? x - 8 : x;
                sy = (y >= 4) ? y - 8 : y;
                s  = x + y;
                issue3(1'b1, 3'(x), 3'(y), 3'd0, 1'b0, 6'(sx * sy));
                issue3(1'b0, 3'(x), 3'(y), 3'(s), (s >= 8), 6'd0);
            end
        end

        repeat (5) @(negedge clk);
        check("sb8_drained", 64'(sb8.size()), 64'(0));
        check("sb3_drained", 64'(sb3.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
